// File: rtl/qea_pkg.sv
// qea_pkg: shared types and constants for the QEA job sequencer
//  state_t      job sequencer FSM states
//  ERR_*        o_error codes
//  one_fixed()  fixed-point 1.0 for a given number of fraction bits; ONE_FIXED is the default
package qea_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_CTX, S_INIT, S_START, S_GUARD, S_RUN, S_RD_ISSUE, S_RD_WAIT, S_RD_HOLD
  } state_t;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_QBIT    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  function automatic logic [63:0] one_fixed(input int frac);
    return 64'd1 << frac;
  endfunction
  localparam logic [63:0] ONE_FIXED = one_fixed(30);
endpackage

// File: rtl/qea_job_sequencer.sv
// qea_job_sequencer: host-side job controller for the QEA engine
//  Per job: load gate contexts into CTX RAM, write |0..0> into STATE RAM, pulse start,
//  count cycles until complete, then stream the final state vector out.
//  Ports:
//   clk, rst (async, active high)
//   i_cmd_*/o_cmd_ready      job request (qbit_num, ctx_num), accepted only in IDLE
//   i_ctx_*/o_ctx_ready      context word stream
//   o_rd_*/i_rd_ready        readback stream, o_rd_last on final word
//   o_busy, o_error, o_exec_cycles   status
//   o_qea_*, i_qea_*         QEA start/complete, CTX RAM write port, STATE RAM port
//  Build option: QEA_SEQ_TIMEOUT_EN adds a RUN watchdog of TIMEOUT_CYCLES (error 2, no readback).
module qea_job_sequencer
  import qea_pkg::*;
#(
  parameter int PE_NUM = 4,
  parameter int PE_NUM_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int STATE_DATA_WIDTH = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH = 6,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int NUM_FRAC_BIT = 30,
  parameter int CYC_WIDTH = 32
`ifdef QEA_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1 << 24
`endif
)(
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_cmd_valid,
  output logic                                      o_cmd_ready,
  input  logic [MAX_QBIT_WIDTH-1:0]                 i_cmd_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]          i_cmd_ctx_num,
  input  logic                                      i_ctx_valid,
  output logic                                      o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]        i_ctx_data,
  output logic                                      o_rd_valid,
  input  logic                                      i_rd_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]        o_rd_data,
  output logic                                      o_rd_last,
  output logic                                      o_busy,
  output logic [1:0]                                o_error,
  output logic [CYC_WIDTH-1:0]                      o_exec_cycles,
  output logic                                      o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]                 o_qea_qbit_num,
  output logic                                      o_qea_ctx_en,
  output logic                                      o_qea_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]        o_qea_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]        o_qea_ctx_data,
  output logic [PE_NUM-1:0]                         o_qea_state_ena,
  output logic [PE_NUM-1:0]                         o_qea_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]               o_qea_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]        o_qea_state_dina,
  input  logic                                      i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]        i_qea_state_dout
);
  localparam int SW = PE_NUM*STATE_DATA_WIDTH;
  localparam int GW = GATE_CONTEXT_ADDR_WIDTH;
  localparam int AW = STATE_ADDR_WIDTH;
  localparam int CW = (GW > AW) ? GW : AW;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(one_fixed(NUM_FRAC_BIT));
  // |0..0>: real part of the top lane of word 0 is 1.0
  localparam logic [SW-1:0] INIT_WORD = {ONE, {(SW-DATA_WIDTH){1'b0}}};
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] ctx_last, ctx_last_n;
  logic [AW-1:0] w_last, w_last_n;
  logic [MAX_QBIT_WIDTH-1:0] qbit_n, k;
  logic [CYC_WIDTH-1:0] cyc_n;
  logic [1:0] err_n;
  logic start_n, ctx_en_n, qbit_ok;
  logic [GW-1:0] ctx_addr_n;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_n;
  logic [PE_NUM-1:0] ena_n, wea_n;
  logic [AW-1:0] addra_n;
  logic [SW-1:0] dina_n, rd_data_n;
  logic [AW:0] w_words;
  assign qbit_ok = i_cmd_qbit_num >= MAX_QBIT_WIDTH'(PE_NUM_WIDTH + 1) &&
                   i_cmd_qbit_num <= MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  assign k = i_cmd_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  assign w_words = (AW+1)'(1) << k;
  assign o_cmd_ready = state == S_IDLE;
  assign o_busy = !o_cmd_ready;
  assign o_ctx_ready = state == S_LOAD_CTX;
  assign o_rd_valid = state == S_RD_HOLD;
  assign o_rd_last = o_rd_valid && AW'(cnt) == w_last;
  assign o_qea_ctx_wea = o_qea_ctx_en;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ctx_last_n = ctx_last;
    w_last_n = w_last;
    qbit_n = o_qea_qbit_num;
    cyc_n = o_exec_cycles;
    err_n = o_error;
    start_n = 1'b0;
    ctx_en_n = 1'b0;
    ctx_addr_n = o_qea_ctx_addr;
    ctx_data_n = o_qea_ctx_data;
    ena_n = '0;
    wea_n = '0;
    addra_n = o_qea_state_addra;
    dina_n = o_qea_state_dina;
    rd_data_n = o_rd_data;
    case (state)
      S_IDLE: if (i_cmd_valid) begin
        err_n = qbit_ok ? ERR_NONE : ERR_QBIT;
        cyc_n = '0;
        if (qbit_ok) begin
          qbit_n = i_cmd_qbit_num;
          // ctx_num >= 2**GW clamps to a full CTX RAM
          ctx_last_n = i_cmd_ctx_num[GW] ? '1 : i_cmd_ctx_num[GW-1:0] - GW'(1);
          w_last_n = AW'(w_words - (AW+1)'(1));
          cnt_n = '0;
          state_n = (i_cmd_ctx_num != '0) ? S_LOAD_CTX : S_INIT;
        end
      end
      S_LOAD_CTX: if (i_ctx_valid) begin
        ctx_en_n = 1'b1;
        ctx_addr_n = GW'(cnt);
        ctx_data_n = i_ctx_data;
        cnt_n = (GW'(cnt) == ctx_last) ? '0 : cnt + CW'(1);
        state_n = (GW'(cnt) == ctx_last) ? S_INIT : S_LOAD_CTX;
      end
      S_INIT: begin
        ena_n = '1;
        wea_n = '1;
        addra_n = AW'(cnt);
        dina_n = (cnt == '0) ? INIT_WORD : '0;
        cnt_n = (AW'(cnt) == w_last) ? '0 : cnt + CW'(1);
        state_n = (AW'(cnt) == w_last) ? S_START : S_INIT;
      end
      S_START: begin
        start_n = 1'b1;
        cyc_n = CYC_WIDTH'(1);
        state_n = S_GUARD;
      end
      // start is visible to QEA here; a complete still high from the previous job is ignored
      S_GUARD: state_n = S_RUN;
      S_RUN: begin
        cyc_n = (&o_exec_cycles) ? o_exec_cycles : o_exec_cycles + CYC_WIDTH'(1);
        if (i_qea_complete) begin
          cnt_n = '0;
          ena_n = '1;
          addra_n = '0;
          state_n = S_RD_ISSUE;
        end
`ifdef QEA_SEQ_TIMEOUT_EN
        else if (cyc_n >= CYC_WIDTH'(TIMEOUT_CYCLES)) begin
          err_n = ERR_TIMEOUT;
          state_n = S_IDLE;
        end
`endif
      end
      // the read strobe is registered on entry, so it is on the RAM port during RD_ISSUE
      S_RD_ISSUE: state_n = S_RD_WAIT;
      S_RD_WAIT: begin
        rd_data_n = i_qea_state_dout;
        state_n = S_RD_HOLD;
      end
      S_RD_HOLD: if (i_rd_ready) begin
        if (AW'(cnt) == w_last) state_n = S_IDLE;
        else begin
          cnt_n = cnt + CW'(1);
          ena_n = '1;
          addra_n = AW'(cnt_n);
          state_n = S_RD_ISSUE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      ctx_last <= '0;
      w_last <= '0;
      o_qea_qbit_num <= '0;
      o_exec_cycles <= '0;
      o_error <= ERR_NONE;
      o_qea_start <= 1'b0;
      o_qea_ctx_en <= 1'b0;
      o_qea_ctx_addr <= '0;
      o_qea_ctx_data <= '0;
      o_qea_state_ena <= '0;
      o_qea_state_wea <= '0;
      o_qea_state_addra <= '0;
      o_qea_state_dina <= '0;
      o_rd_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ctx_last <= ctx_last_n;
      w_last <= w_last_n;
      o_qea_qbit_num <= qbit_n;
      o_exec_cycles <= cyc_n;
      o_error <= err_n;
      o_qea_start <= start_n;
      o_qea_ctx_en <= ctx_en_n;
      o_qea_ctx_addr <= ctx_addr_n;
      o_qea_ctx_data <= ctx_data_n;
      o_qea_state_ena <= ena_n;
      o_qea_state_wea <= wea_n;
      o_qea_state_addra <= addra_n;
      o_qea_state_dina <= dina_n;
      o_rd_data <= rd_data_n;
    end
  end
endmodule

// File: tb/tb_qea_job_sequencer.sv
// tb_qea_job_sequencer: directed self-checking bench with a stub QEA and STATE RAM model
module tb_qea_job_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic i_cmd_valid, o_cmd_ready, i_ctx_valid, o_ctx_ready, o_rd_valid, i_rd_ready, o_rd_last, o_busy;
  logic [5:0] i_cmd_qbit_num, o_qea_qbit_num;
  logic [16:0] i_cmd_ctx_num;
  logic [63:0] i_ctx_data, o_qea_ctx_data;
  logic [255:0] o_rd_data, o_qea_state_dina, i_qea_state_dout;
  logic [1:0] o_error;
  logic [31:0] o_exec_cycles;
  logic o_qea_start, o_qea_ctx_en, o_qea_ctx_wea, i_qea_complete;
  logic [15:0] o_qea_ctx_addr, o_qea_state_addra;
  logic [3:0] o_qea_state_ena, o_qea_state_wea;
  qea_job_sequencer #(
    .CYC_WIDTH(32)
`ifdef QEA_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_qbit_num(i_cmd_qbit_num), .i_cmd_ctx_num(i_cmd_ctx_num),
    .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
    .o_busy(o_busy), .o_error(o_error), .o_exec_cycles(o_exec_cycles),
    .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
    .o_qea_ctx_en(o_qea_ctx_en), .o_qea_ctx_wea(o_qea_ctx_wea),
    .o_qea_ctx_addr(o_qea_ctx_addr), .o_qea_ctx_data(o_qea_ctx_data),
    .o_qea_state_ena(o_qea_state_ena), .o_qea_state_wea(o_qea_state_wea),
    .o_qea_state_addra(o_qea_state_addra), .o_qea_state_dina(o_qea_state_dina),
    .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout)
  );
  // stub QEA: complete rises 500 cycles after the start pulse and stays high
  logic stub_en;
  logic [15:0] stub_cnt;
  always @(posedge clk or posedge rst)
    if (rst) stub_cnt <= '0;
    else if (o_qea_start) stub_cnt <= 16'd1;
    else if (stub_cnt != 0 && stub_cnt < 16'd500) stub_cnt <= stub_cnt + 16'd1;
  assign i_qea_complete = stub_en && stub_cnt == 16'd500;
  function automatic logic [255:0] pat(input int i);
    logic [31:0] w;
    w = 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
    return {w, ~w, w ^ 32'hFFFF, w + 32'd7, w, ~w, w - 32'd3, w ^ 32'h0F0F_0000};
  endfunction
  // STATE RAM model; the stub overwrites it with a result pattern on start
  logic [255:0] mem [0:255];
  always @(posedge clk) begin
    if (o_qea_start) for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    else if (|o_qea_state_ena && |o_qea_state_wea) mem[o_qea_state_addra[7:0]] <= o_qea_state_dina;
    if (|o_qea_state_ena && ~|o_qea_state_wea) i_qea_state_dout <= mem[o_qea_state_addra[7:0]];
  end
  logic [15:0] ctx_a_q[$];
  logic [63:0] ctx_d_q[$];
  logic [15:0] init_a_q[$];
  logic [255:0] init_d_q[$];
  logic [3:0] init_e_q[$];
  logic [255:0] rd_d_q[$];
  logic rd_l_q[$];
  int n_start = 0;
  int stab_err = 0;
  logic held = 1'b0;
  logic [255:0] held_d;
  always @(negedge clk) begin
    if (o_qea_ctx_en) begin
      ctx_a_q.push_back(o_qea_ctx_addr);
      ctx_d_q.push_back(o_qea_ctx_data);
    end
    if (|o_qea_state_wea) begin
      init_a_q.push_back(o_qea_state_addra);
      init_d_q.push_back(o_qea_state_dina);
      init_e_q.push_back(o_qea_state_ena);
    end
    if (o_qea_start) n_start <= n_start + 1;
    if (o_rd_valid) begin
      if (held && o_rd_data !== held_d) stab_err <= stab_err + 1;
      held <= !i_rd_ready;
      held_d <= o_rd_data;
      if (i_rd_ready) begin
        rd_d_q.push_back(o_rd_data);
        rd_l_q.push_back(o_rd_last);
      end
    end else held <= 1'b0;
  end
  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_q();
    ctx_a_q.delete(); ctx_d_q.delete(); init_a_q.delete(); init_d_q.delete();
    init_e_q.delete(); rd_d_q.delete(); rd_l_q.delete();
  endtask
  task automatic send_cmd(input int q, input int n);
    i_cmd_valid = 1'b1;
    i_cmd_qbit_num = 6'(q);
    i_cmd_ctx_num = 17'(n);
    tick();
    i_cmd_valid = 1'b0;
  endtask
  logic [63:0] ctx_words [0:166];
  task automatic send_ctx(input int n);
    logic acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      if (i % 7 == 3) begin
        i_ctx_valid = 1'b0;
        tick();
      end
      i_ctx_valid = 1'b1;
      i_ctx_data = ctx_words[i];
      guard = 0;
      do begin
        @(negedge clk);
        acc = o_ctx_ready;
        tick();
        guard++;
      end while (!acc && guard < 20);
    end
    i_ctx_valid = 1'b0;
  endtask
  task automatic readback(input int w);
    int c = 0;
    while (rd_d_q.size() < w && c < 4000) begin
      i_rd_ready = $urandom_range(0, 9) >= 3;
      tick();
      c++;
    end
    i_rd_ready = 1'b0;
    check("rd_count", 256'(rd_d_q.size()), 256'(w));
  endtask
  task automatic wait_idle(input int budget);
    int c = 0;
    while (o_busy && c < budget) begin
      tick();
      c++;
    end
    check("idle_reached", o_busy, 1'b0);
  endtask
  task automatic check_rd(input int w);
    int bad = 0;
    for (int i = 0; i < w; i++)
      if (rd_d_q[i] !== pat(i) || rd_l_q[i] !== (i == w - 1)) bad++;
    check("rd_data_last", 256'(bad), 256'(0));
    check("stall_stable", 256'(stab_err), 256'(0));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int bad, s0, c0, i0;
    i_cmd_valid = 0; i_cmd_qbit_num = 0; i_cmd_ctx_num = 0;
    i_ctx_valid = 0; i_ctx_data = 0; i_rd_ready = 0; stub_en = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", o_cmd_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_error", o_error, 2'd0);
    check("rst_exec", o_exec_cycles, 32'd0);
    check("rst_strobes", {o_qea_start, o_qea_ctx_en, o_qea_state_ena, o_rd_valid, o_ctx_ready}, 8'd0);
    rst = 0;
    tick();
    // job 1: qbit 8, 167 contexts
    for (int i = 0; i < 167; i++) ctx_words[i] = {$urandom, $urandom};
    clear_q();
    s0 = n_start;
    send_cmd(8, 167);
    check("j1_ctx_ready", o_ctx_ready, 1'b1);
    check("j1_busy", o_busy, 1'b1);
    send_ctx(167);
    send_cmd(1, 0);
    readback(64);
    wait_idle(50);
    check("j1_ctx_count", 256'(ctx_a_q.size()), 256'(167));
    bad = 0;
    for (int i = 0; i < ctx_a_q.size(); i++)
      if (ctx_a_q[i] !== 16'(i) || ctx_d_q[i] !== ctx_words[i]) bad++;
    check("j1_ctx_words", 256'(bad), 256'(0));
    check("j1_init_count", 256'(init_a_q.size()), 256'(64));
    check("j1_init_word0", init_d_q[0], {32'h4000_0000, 224'h0});
    bad = 0;
    for (int i = 0; i < init_a_q.size(); i++)
      if (init_a_q[i] !== 16'(i) || init_e_q[i] !== 4'hF || (i > 0 && init_d_q[i] !== 256'h0)) bad++;
    check("j1_init_words", 256'(bad), 256'(0));
    check("j1_start_pulses", 256'(n_start - s0), 256'(1));
    check("j1_qbit_num", o_qea_qbit_num, 6'd8);
    check("j1_exec_cycles", o_exec_cycles, 32'd501);
    check("j1_error_ignored_cmd", o_error, 2'd0);
    check_rd(64);
    // bad qubit counts at both edges of the legal range
    s0 = n_start; c0 = ctx_a_q.size(); i0 = init_a_q.size();
    send_cmd(1, 5);
    check("bad1_error", o_error, 2'd1);
    check("bad1_cmd_ready", o_cmd_ready, 1'b1);
    repeat (5) tick();
    check("bad1_no_strobes", 256'(n_start - s0 + ctx_a_q.size() - c0 + init_a_q.size() - i0), 256'(0));
    send_cmd(19, 0);
    check("bad19_error", o_error, 2'd1);
    check("bad19_busy", o_busy, 1'b0);
    // job 2: smallest legal job, contexts reused
    clear_q();
    send_cmd(3, 0);
    check("j2_error_clear", o_error, 2'd0);
    check("j2_exec_clear", o_exec_cycles, 32'd0);
    check("j2_skip_load", o_ctx_ready, 1'b0);
    readback(2);
    wait_idle(50);
    check("j2_ctx_count", 256'(ctx_a_q.size()), 256'(0));
    check("j2_init_count", 256'(init_a_q.size()), 256'(2));
    check("j2_exec_cycles", o_exec_cycles, 32'd501);
    check_rd(2);
    // reset in the middle of INIT
    clear_q();
    send_cmd(8, 0);
    bad = 0;
    do begin
      @(negedge clk);
      bad++;
    end while (!(|o_qea_state_wea && o_qea_state_addra == 16'd20) && bad < 100);
    rst = 1;
    tick();
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_outputs", {o_qea_state_ena, o_qea_state_wea, o_qea_state_addra, o_qea_start, o_cmd_ready}, 26'd1);
    check("mid_rst_writes", 256'(init_a_q.size()), 256'(21));
    tick();
    rst = 0;
    repeat (30) tick();
    check("mid_rst_no_more_writes", 256'(init_a_q.size()), 256'(21));
`ifdef QEA_SEQ_TIMEOUT_EN
    clear_q();
    stub_en = 0;
    send_cmd(3, 0);
    wait_idle(400);
    check("to_error", o_error, 2'd2);
    check("to_exec", o_exec_cycles, 32'd100);
    check("to_no_readback", 256'(rd_d_q.size()), 256'(0));
    stub_en = 1;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
